// File: rtl/gig_ram_wr_arb.sv
// ============================================================================
//  gig_ram_wr_arb : write-port arbiter for the Gigatron RAM port B.
//  The CPU has priority; loader writes are queued and drained in idle cycles.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gig_ram_wr_arb #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_flush,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic [15:0]   conflicts
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW+7:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [LW-1:0]  level_q;
    logic [LW-1:0]  level_d;
    logic [15:0]    conflicts_q;
    logic           ram_we_q;
    logic [AW-1:0]  ram_addr_q;
    logic [7:0]     ram_data_q;

    logic           w_not_empty;
    logic           w_push;
    logic           w_pop;
    logic [AW+7:0]  w_head;

    assign w_not_empty = (level_q != '0);
    // Ready looks only at the registered level, so a same-cycle pop never frees a slot.
    assign ld_ready    = (level_q != LW'(DEPTH)) && !ld_flush;
    assign w_push      = ld_valid && ld_ready;
    assign w_pop       = !cpu_we && w_not_empty && !ld_flush;
    assign w_head      = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (ld_flush) begin
            level_d = '0;
        end else if (w_push && !w_pop) begin
            level_d = level_q + LW'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage needs no reset: level_q alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {ld_addr, ld_data};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (ld_flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            conflicts_q <= '0;
        end else if (cpu_we && w_not_empty && (conflicts_q != 16'hFFFF)) begin
            conflicts_q <= conflicts_q + 16'd1;
        end
    end

    // Idle cycles keep the last address/data so port B sees no needless toggling.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else if (cpu_we) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= cpu_addr;
            ram_data_q <= cpu_data;
        end else if (w_pop) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= w_head[AW+7:8];
            ram_data_q <= w_head[7:0];
        end else begin
            ram_we_q   <= 1'b0;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign level     = level_q;
    assign busy      = w_not_empty;
    assign conflicts = conflicts_q;

endmodule

`default_nettype wire

// File: tb/tb_gig_ram_wr_arb.sv
// ============================================================================
//  tb_gig_ram_wr_arb : scoreboard bench for gig_ram_wr_arb.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gig_ram_wr_arb;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_flush;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic [2:0]  level;
    logic        busy;
    logic [15:0] conflicts;

    gig_ram_wr_arb #(.DEPTH(4), .AW(16)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_flush  (ld_flush),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .level     (level),
        .busy      (busy),
        .conflicts (conflicts)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_wr(input int at, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.cyc = at;
        e.a   = a;
        e.d   = d;
        q.push_back(e);
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clock) begin
        if (rst_n === 1'b1 && ram_we === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none (cycle %0d)",
                         ram_addr, ram_data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", {16'h0, ram_addr}, {16'h0, e.a});
                chk("wr_data", {24'h0, ram_data}, {24'h0, e.d});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        ld_flush = 1'b0;
        #22 rst_n = 1'b1;
        tick();
        tick();

        // Reset / idle state
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_conflicts", conflicts, 0);

        // Single CPU write: one-cycle latency
        cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_data = 8'hA5;
        expect_wr(cyc + 1, 16'h0123, 8'hA5);
        tick();
        cpu_we = 1'b0;
        tick();

        // Single loader write: issued the edge after the push
        ld_valid = 1'b1; ld_addr = 16'h8000; ld_data = 8'h11;
        expect_wr(cyc + 2, 16'h8000, 8'h11);
        tick();
        ld_valid = 1'b0;
        chk("ld1_level_after_push", level, 1);
        chk("ld1_busy", busy, 1);
        tick();
        chk("ld1_level_after_issue", level, 0);
        tick();

        // Fill the FIFO while the CPU writes every cycle
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1'b1; cpu_addr = 16'h0100 + 16'(i); cpu_data = 8'hC0 + 8'(i);
            ld_valid = 1'b1; ld_addr = 16'h9000 + 16'(i); ld_data = 8'(i + 1);
            expect_wr(cyc + 1, 16'h0100 + 16'(i), 8'hC0 + 8'(i));
            tick();
        end
        chk("fill_level", level, 4);
        chk("fill_ld_ready", ld_ready, 0);
        chk("fill_conflicts", conflicts, 3);
        // A fifth request offered while full must be dropped by the handshake
        cpu_we = 1'b0; ld_addr = 16'h9004; ld_data = 8'h05;
        for (int i = 0; i < 4; i++) expect_wr(cyc + 1 + i, 16'h9000 + 16'(i), 8'(i + 1));
        tick();
        ld_valid = 1'b0;
        chk("drain_level_first", level, 3);
        tick(); tick(); tick();
        chk("drain_level_end", level, 0);
        chk("drain_conflicts_hold", conflicts, 3);
        tick();

        // Interleave: queue 2 entries, then CPU, LD1, CPU, LD2
        cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_data = 8'hD0;
        ld_valid = 1'b1; ld_addr = 16'hA001; ld_data = 8'h21;
        expect_wr(cyc + 1, 16'h0200, 8'hD0);
        tick();
        cpu_addr = 16'h0201; cpu_data = 8'hD1;
        ld_addr = 16'hA002; ld_data = 8'h22;
        expect_wr(cyc + 1, 16'h0201, 8'hD1);
        tick();
        ld_valid = 1'b0;
        cpu_addr = 16'hB000; cpu_data = 8'h31;
        expect_wr(cyc + 1, 16'hB000, 8'h31);
        expect_wr(cyc + 2, 16'hA001, 8'h21);
        expect_wr(cyc + 3, 16'hB001, 8'h32);
        expect_wr(cyc + 4, 16'hA002, 8'h22);
        tick();
        cpu_we = 1'b0;
        tick();
        cpu_we = 1'b1; cpu_addr = 16'hB001; cpu_data = 8'h32;
        tick();
        cpu_we = 1'b0;
        tick();
        chk("ilv_level", level, 0);
        chk("ilv_conflicts", conflicts, 6);
        tick();

        // Flush three queued entries
        for (int i = 0; i < 3; i++) begin
            cpu_we = 1'b1; cpu_addr = 16'h0300 + 16'(i); cpu_data = 8'hE0 + 8'(i);
            ld_valid = 1'b1; ld_addr = 16'hF000 + 16'(i); ld_data = 8'h40 + 8'(i);
            expect_wr(cyc + 1, 16'h0300 + 16'(i), 8'hE0 + 8'(i));
            tick();
        end
        cpu_we = 1'b0; ld_valid = 1'b0;
        chk("flush_pre_level", level, 3);
        ld_flush = 1'b1;
        #1;
        chk("flush_ld_ready_low", ld_ready, 0);
        tick();
        chk("flush_level", level, 0);
        ld_flush = 1'b0;
        #1;
        chk("flush_ld_ready_high", ld_ready, 1);
        tick(); tick(); tick();
        chk("flush_conflicts", conflicts, 8);

        // Reset in the middle of a drain
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1'b1; cpu_addr = 16'h0400 + 16'(i); cpu_data = 8'h70 + 8'(i);
            ld_valid = 1'b1; ld_addr = 16'h5000 + 16'(i); ld_data = 8'h60 + 8'(i);
            expect_wr(cyc + 1, 16'h0400 + 16'(i), 8'h70 + 8'(i));
            tick();
        end
        cpu_we = 1'b0; ld_valid = 1'b0;
        expect_wr(cyc + 1, 16'h5000, 8'h60);
        expect_wr(cyc + 2, 16'h5001, 8'h61);
        tick(); tick();
        chk("mid_level", level, 2);
        @(negedge clock);
        #1 rst_n = 1'b0;
        #1;
        chk("async_ram_we", ram_we, 0);
        chk("async_level", level, 0);
        chk("async_conflicts", conflicts, 0);
        @(negedge clock);
        #1 rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_level", level, 0);
        chk("post_rst_ld_ready", ld_ready, 1);

        // Fresh traffic after reset goes through cleanly
        ld_valid = 1'b1; ld_addr = 16'hC000; ld_data = 8'h55;
        expect_wr(cyc + 2, 16'hC000, 8'h55);
        tick();
        ld_valid = 1'b0;
        tick(); tick(); tick();

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
